// File: rtl/core101_pkg.sv
// Shared constants and helpers for the pipe_chain block: default payload width,
// maximum stage count, performance-counter width and a saturating increment.
package core101_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int MAX_NUM_STAGES     = 16;
  localparam int CNT_WIDTH          = 32;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t value);
    if (value == {CNT_WIDTH{1'b1}}) begin
      sat_inc = value;
    end else begin
      sat_inc = value + cnt_t'(1);
    end
  endfunction

endpackage

// File: rtl/pipe_chain_if.sv
// Handshake, flush and debug/performance bundle between a producer/consumer
// (master) and the pipe_chain datapath (slave).
interface pipe_chain_if
  import core101_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_STAGES = 4
);

  logic                  in_valid_in;
  logic                  in_ready_out;
  logic [DATA_WIDTH-1:0] in_data_in;
  logic                  out_valid_out;
  logic                  out_ready_in;
  logic [DATA_WIDTH-1:0] out_data_out;
  logic [NUM_STAGES-1:0] flush_in;
  logic [NUM_STAGES-1:0] stage_valid_out;
  cnt_t                  stall_count_out;
  cnt_t                  bubble_count_out;

  modport master (
    output in_valid_in, in_data_in, out_ready_in, flush_in,
    input  in_ready_out, out_valid_out, out_data_out, stage_valid_out,
           stall_count_out, bubble_count_out
  );

  modport slave (
    input  in_valid_in, in_data_in, out_ready_in, flush_in,
    output in_ready_out, out_valid_out, out_data_out, stage_valid_out,
           stall_count_out, bubble_count_out
  );

endinterface

// File: rtl/pipe_chain_stage.sv
// pipe_stage: one valid+data register of the chain. Flush clears only the
// valid bit and wins over load; data follows load alone.
module pipe_stage
  import core101_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  // Stage register: reset, then flush/load/hold for valid, load/hold for data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= i_valid;
      end else begin
        r_valid <= r_valid;
      end
      if (i_load) begin
        r_data <= i_data;
      end else begin
        r_data <= r_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_chain.sv
// pipe_chain: NUM_STAGES-deep valid/ready register chain with bubble collapse,
// per-stage flush, and optional stall/bubble counters (PIPE_CHAIN_PERF_EN).
module pipe_chain
  import core101_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_STAGES = 4
) (
  input  logic          clock_in,
  input  logic          reset_in,
  pipe_chain_if.slave   bus
);

  logic [NUM_STAGES:0]                   w_ready;
  logic [NUM_STAGES-1:0]                 w_valid;
  logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] w_data;
  logic [NUM_STAGES-1:0]                 w_up_valid;
  logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] w_up_data;

  if ((NUM_STAGES < 1) || (NUM_STAGES > MAX_NUM_STAGES)) begin : g_bad_cfg
    $error("pipe_chain: NUM_STAGES out of range");
  end

  // Ready ripples from the consumer back to stage 0; flush is deliberately absent.
  always_comb begin
    w_ready = {(NUM_STAGES+1){1'b0}};
    w_ready[NUM_STAGES] = bus.out_ready_in;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      w_ready[i] = !w_valid[i] || w_ready[i+1];
    end
  end

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign w_up_valid[gi] = bus.in_valid_in;
      assign w_up_data[gi]  = bus.in_data_in;
    end else begin : g_body
      assign w_up_valid[gi] = w_valid[gi-1];
      assign w_up_data[gi]  = w_data[gi-1];
    end

    pipe_stage #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_stage (
      .i_clk   (clock_in),
      .i_rst   (reset_in),
      .i_load  (w_ready[gi]),
      .i_flush (bus.flush_in[gi]),
      .i_valid (w_up_valid[gi]),
      .i_data  (w_up_data[gi]),
      .o_valid (w_valid[gi]),
      .o_data  (w_data[gi])
    );
  end

  assign bus.in_ready_out    = w_ready[0];
  assign bus.out_valid_out   = w_valid[NUM_STAGES-1];
  assign bus.out_data_out    = w_data[NUM_STAGES-1];
  assign bus.stage_valid_out = w_valid;

`ifdef PIPE_CHAIN_PERF_EN
  cnt_t r_stall_count;
  cnt_t r_bubble_count;

  // Saturating stall/bubble counters observed at the chain output.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_stall_count  <= {CNT_WIDTH{1'b0}};
      r_bubble_count <= {CNT_WIDTH{1'b0}};
    end else begin
      if (w_valid[NUM_STAGES-1] && !bus.out_ready_in) begin
        r_stall_count <= sat_inc(r_stall_count);
      end else begin
        r_stall_count <= r_stall_count;
      end
      if (!w_valid[NUM_STAGES-1]) begin
        r_bubble_count <= sat_inc(r_bubble_count);
      end else begin
        r_bubble_count <= r_bubble_count;
      end
    end
  end

  assign bus.stall_count_out  = r_stall_count;
  assign bus.bubble_count_out = r_bubble_count;
`else
  assign bus.stall_count_out  = {CNT_WIDTH{1'b0}};
  assign bus.bubble_count_out = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain: a 4-stage instance checked through a
// scoreboard plus point checks, and a 1-stage instance checked directly.
module tb_pipe_chain;

  logic clk = 1'b0;
  logic reset_in;
  int   n_chk = 0;
  int   n_err = 0;
  logic [31:0] sb[$];

`ifdef PIPE_CHAIN_PERF_EN
  localparam logic PERF = 1'b1;
`else
  localparam logic PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  pipe_chain_if #(.DATA_WIDTH(32), .NUM_STAGES(4)) bus4 ();
  pipe_chain_if #(.DATA_WIDTH(8),  .NUM_STAGES(1)) bus1 ();

  pipe_chain #(.DATA_WIDTH(32), .NUM_STAGES(4)) dut (
    .clock_in (clk),
    .reset_in (reset_in),
    .bus      (bus4)
  );

  pipe_chain #(.DATA_WIDTH(8), .NUM_STAGES(1)) dut1 (
    .clock_in (clk),
    .reset_in (reset_in),
    .bus      (bus1)
  );

  function automatic logic [31:0] exp_cnt(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic rdy, input logic [3:0] fl);
    bus4.in_valid_in  = v;
    bus4.in_data_in   = d;
    bus4.out_ready_in = rdy;
    bus4.flush_in     = fl;
  endtask

  task automatic drive1(input logic v, input logic [7:0] d, input logic rdy);
    bus1.in_valid_in  = v;
    bus1.in_data_in   = d;
    bus1.out_ready_in = rdy;
  endtask

  // Mid-cycle sample: record accepted inputs, pop and compare delivered outputs.
  task automatic at_neg();
    logic [31:0] exp_v;
    @(negedge clk);
    if (!reset_in) begin
      if (bus4.in_valid_in && bus4.in_ready_out && !bus4.flush_in[0])
        sb.push_back(bus4.in_data_in);
      if (bus4.out_valid_out && bus4.out_ready_in) begin
        n_chk++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL sb_unexpected observed=0x%0h expected=no_item", bus4.out_data_out);
        end
        if (sb.size() != 0) begin
          exp_v = sb.pop_front();
          check("sb_data", bus4.out_data_out, exp_v);
        end
      end
    end
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_in = 1'b1;
    drive(1'b0, 32'd0, 1'b1, 4'b0000);
    drive1(1'b0, 8'd0, 1'b1);
    bus1.flush_in = 1'b0;
    to_next();
    at_neg();
    to_next();
    reset_in = 1'b0;

    // Four items back to back, consumer always ready: outputs on cycles 4..7
    for (int c = 0; c < 9; c++) begin
      drive(c < 4, (c < 4) ? 32'h11 + 32'(c) : 32'd0, 1'b1, 4'b0000);
      at_neg();
      if (c == 0) begin
        check("rst_out_valid", bus4.out_valid_out, 32'd0);
        check("rst_in_ready", bus4.in_ready_out, 32'd1);
        check("rst_out_data", bus4.out_data_out, 32'd0);
        check("rst_stage_valid", bus4.stage_valid_out, 32'd0);
        check("rst_stall", bus4.stall_count_out, 32'd0);
        check("rst_bubble", bus4.bubble_count_out, 32'd0);
      end
      check("lat_out_valid", bus4.out_valid_out, (c >= 4 && c < 8) ? 32'd1 : 32'd0);
      if (c >= 4 && c < 8) check("lat_out_data", bus4.out_data_out, 32'h11 + 32'(c - 4));
      if (c == 4 || c == 8) check("lat_bubble", bus4.bubble_count_out, exp_cnt(4));
      to_next();
    end

    // Fill with 0x21..0x24 (cycles 9..12)
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h21 + 32'(k), 1'b1, 4'b0000);
      at_neg();
      to_next();
    end

    // Full pipeline, consumer stalled for three cycles
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h25, 1'b0, 4'b0000);
      at_neg();
      check("stall_in_ready", bus4.in_ready_out, 32'd0);
      check("stall_out_data", bus4.out_data_out, 32'h21);
      check("stall_stage_valid", bus4.stage_valid_out, 32'hF);
      if (k == 0) begin
        check("stall_cnt_before", bus4.stall_count_out, 32'd0);
        check("bubble_cnt_before", bus4.bubble_count_out, exp_cnt(9));
      end
      to_next();
    end

    // Still stalled, kill stages 1 and 2 (items 0x23 and 0x22)
    drive(1'b1, 32'h25, 1'b0, 4'b0110);
    at_neg();
    check("stall_cnt_after", bus4.stall_count_out, exp_cnt(3));
    check("bubble_cnt_after", bus4.bubble_count_out, exp_cnt(9));
    check("flush_in_ready", bus4.in_ready_out, 32'd0);
    to_next();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i] == 32'h22 || sb[i] == 32'h23) sb.delete(i);
    end

    drive(1'b1, 32'h25, 1'b1, 4'b0000);
    at_neg();
    check("flush_stage_valid", bus4.stage_valid_out, 32'h9);
    check("flush_out_data", bus4.out_data_out, 32'h21);
    check("flush_in_ready_resume", bus4.in_ready_out, 32'd1);
    check("flush_stall_cnt", bus4.stall_count_out, exp_cnt(4));
    to_next();

    // Input accepted in the same cycle stage 0 is flushed: 0x31 must vanish
    drive(1'b1, 32'h31, 1'b1, 4'b0001);
    at_neg();
    check("flush0_in_ready", bus4.in_ready_out, 32'd1);
    to_next();

    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 32'd0, 1'b1, 4'b0000);
      at_neg();
      to_next();
    end
    drive(1'b0, 32'd0, 1'b1, 4'b0000);
    at_neg();
    check("drain_stage_valid", bus4.stage_valid_out, 32'd0);
    check("drain_out_valid", bus4.out_valid_out, 32'd0);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    to_next();

    // Three items in flight, then a one-cycle reset drops them
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h41 + 32'(k), 1'b1, 4'b0000);
      at_neg();
      to_next();
    end
    reset_in = 1'b1;
    drive(1'b0, 32'd0, 1'b1, 4'b0000);
    at_neg();
    to_next();
    reset_in = 1'b0;
    sb.delete();
    at_neg();
    check("mrst_stage_valid", bus4.stage_valid_out, 32'd0);
    check("mrst_out_data", bus4.out_data_out, 32'd0);
    check("mrst_out_valid", bus4.out_valid_out, 32'd0);
    check("mrst_in_ready", bus4.in_ready_out, 32'd1);
    check("mrst_stall", bus4.stall_count_out, 32'd0);
    check("mrst_bubble", bus4.bubble_count_out, 32'd0);
    to_next();
    for (int k = 0; k < 5; k++) begin
      at_neg();
      check("mrst_no_stale", bus4.out_valid_out, 32'd0);
      to_next();
    end

    // Single-stage instance: in_ready = !valid || out_ready
    drive1(1'b1, 8'hA5, 1'b0);
    at_neg();
    check("s1_in_ready_empty", bus1.in_ready_out, 32'd1);
    check("s1_out_valid_empty", bus1.out_valid_out, 32'd0);
    to_next();
    drive1(1'b1, 8'h5A, 1'b0);
    at_neg();
    check("s1_in_ready_full", bus1.in_ready_out, 32'd0);
    check("s1_out_valid_full", bus1.out_valid_out, 32'd1);
    check("s1_out_data_full", bus1.out_data_out, 32'hA5);
    to_next();
    drive1(1'b1, 8'h5A, 1'b1);
    at_neg();
    check("s1_in_ready_pass", bus1.in_ready_out, 32'd1);
    check("s1_out_data_pass", bus1.out_data_out, 32'hA5);
    to_next();
    drive1(1'b0, 8'h00, 1'b1);
    at_neg();
    check("s1_out_valid_next", bus1.out_valid_out, 32'd1);
    check("s1_out_data_next", bus1.out_data_out, 32'h5A);
    to_next();
    at_neg();
    check("s1_out_valid_drain", bus1.out_valid_out, 32'd0);
    to_next();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: payload width per stage.
REQ-002 SHALL have parameter NUM_STAGES, default 4: number of register stages, legal range 1..16.
REQ-003 SHALL have port clock_in, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_in, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid_in, input, 1: producer offers in_data_in.
REQ-006 SHALL have port in_ready_out, output, 1: stage 0 can accept this cycle.
REQ-007 SHALL have port in_data_in, input, DATA_WIDTH: payload into stage 0.
REQ-008 SHALL have port out_valid_out, output, 1: last stage holds a valid item.
REQ-009 SHALL have port out_ready_in, input, 1: consumer accepts the last-stage item.
REQ-010 SHALL have port out_data_out, output, DATA_WIDTH: payload of the last stage.
REQ-011 SHALL have port flush_in, input, NUM_STAGES: bit i kills stage i (bit 0 = youngest).
REQ-012 SHALL have port stage_valid_out, output, NUM_STAGES: debug, per-stage valid bits.
REQ-013 SHALL have port stall_count_out, output, 32: cycles with out_valid_out=1 and out_ready_in=0.
REQ-014 SHALL have port bubble_count_out, output, 32: cycles with out_valid_out=0.

Function
REQ-015 SHALL define stage i ready as !valid[i] || ready[i+1], with ready[NUM_STAGES] = out_ready_in (bubble collapse, full throughput).
REQ-016 SHALL drive in_ready_out = ready[0], with no combinational dependence on flush_in.
REQ-017 SHALL load stage i when ready[i]=1, from stage i-1 (or from in_valid_in/in_data_in for i=0); the new valid equals the upstream valid.
REQ-018 SHALL hold data and valid of a stage when ready[i]=0; payload SHALL be unchanged under stall.
REQ-019 SHALL give latency NUM_STAGES cycles from input handshake to out_valid_out when downstream is never stalled.
REQ-020 SHALL force valid[i] to 0 at the edge on which flush_in[i]=1, overriding any hold or load into stage i; data registers are not cleared by flush.
REQ-021 SHALL count an input handshake (in_valid_in && in_ready_out) as accepted even when flush_in[0]=1 in the same cycle; that item is discarded.
REQ-022 SHALL drive out_valid_out directly from valid[NUM_STAGES-1]; an output handshake in the same cycle as flush_in[NUM_STAGES-1]=1 SHALL count as delivered.
REQ-023 SHALL preserve item order; it SHALL never duplicate or reorder items.
REQ-024 SHALL, when NUM_STAGES=1, behave as a single skid-free register: in_ready_out = !valid[0] || out_ready_in.

Reset
REQ-025 SHALL, on reset_in=1 at an edge, clear all valid bits, all stage data, and both counters to 0.
REQ-026 SHALL give reset priority over flush_in and handshakes; a reset mid-stream SHALL drop all in-flight items.
REQ-027 SHALL drive, from the cycle after reset, out_valid_out=0, in_ready_out=1, out_data_out=0, stage_valid_out=0.

Configuration
REQ-028 SHALL, with macro PIPE_CHAIN_PERF_EN defined, increment stall_count_out and bubble_count_out per REQ-013/014, saturating at 32'hFFFFFFFF.
REQ-029 SHALL, without PIPE_CHAIN_PERF_EN, keep both counter ports present but tied to 0, with no counter flops.

Structure
REQ-030 SHALL place default DATA_WIDTH, max NUM_STAGES and the counter width (32) in shared package core101_pkg.
REQ-031 SHALL implement one sub-module pipe_stage (valid plus data register with load, flush and reset), instantiated NUM_STAGES times by a generate loop.

Verification
REQ-032 SHALL cover: NUM_STAGES=4, out_ready_in=1, inputs 0x11..0x14 on consecutive cycles -> outputs 0x11..0x14 on cycles 4..7, bubble_count_out stops growing while those items are delivered.
REQ-033 SHALL cover: pipeline full, out_ready_in=0 for 3 cycles -> in_ready_out=0, out_data_out stable, stall_count_out += 3 (PERF_EN build).
REQ-034 SHALL cover: valid items in stages 1 and 2, flush_in=4'b0110 for one cycle -> those items never appear at the output, stages 0 and 3 unaffected.
REQ-035 SHALL cover: in_valid_in=1 with flush_in[0]=1 -> in_ready_out=1, and the item is absent at the output.
REQ-036 SHALL cover: reset_in=1 for one cycle with 3 items in flight -> next cycle stage_valid_out=0, out_data_out=0, counters=0, and no stale items emitted.
REQ-037 SHALL cover: build without PIPE_CHAIN_PERF_EN running REQ-033's stimulus -> stall_count_out and bubble_count_out remain 0.
